stream_demux: RTL
=================

Name: stream_demux

Overview:
- Splits one packetised QoS stream into STREAM_COUNT output streams. Each packet is routed by its destination index.
- Sits on the far side of the stream arbiter: it takes the single arbitrated stream and returns each packet to its target channel.
- Routing is locked per packet. Each output has a one-beat register slice. Packets with an out-of-range destination are consumed and discarded.

Parameters:
- T_DATA_WIDTH, 8, payload width per beat
- T_QOS__WIDTH, 4, QoS field width, passed through unchanged
- STREAM_COUNT, 2, number of output streams (1..8)
- T_DEST_WIDTH, $clog2(STREAM_COUNT)+1, destination index width; includes one extra bit so out-of-range values can be encoded

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- s_data_i  in  T_DATA_WIDTH  input beat payload
- s_qos_i  in  T_QOS__WIDTH  input QoS
- s_dest_i  in  T_DEST_WIDTH  destination index; sampled on the first beat of a packet only
- s_last_i  in  1  last beat of the packet
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  input beat accepted when s_valid_i && s_ready_o
- m_data_o  out  T_DATA_WIDTH x STREAM_COUNT  per-output payload
- m_qos_o  out  T_QOS__WIDTH x STREAM_COUNT  per-output QoS
- m_last_o  out  STREAM_COUNT  per-output last
- m_valid_o  out  STREAM_COUNT  per-output valid
- m_ready_i  in  STREAM_COUNT  per-output ready
- busy_o  out  1  high while a packet is open (state != IDLE)

Behaviour:
- Reset: rst is asynchronous and active-high.
  - Clears state to IDLE and sel to 0.
  - Clears m_valid_o, m_data_o, m_qos_o and m_last_o to all 0; busy_o=0.
  - s_ready_o is combinational and therefore 0 while rst is high.
- FSM states:
  - IDLE: waiting for the first beat of a packet.
  - ROUTE: packet open, destination locked in sel.
  - DROP: packet open, destination out of range, beats discarded.
- Effective destination: d = s_dest_i in IDLE, d = sel in ROUTE.
- s_ready_o:
  - IDLE with s_dest_i >= STREAM_COUNT: 1.
  - DROP: 1.
  - Otherwise: ~m_valid_o[d] | m_ready_i[d].
  - May depend on s_valid_i and s_dest_i. Must never depend on s_ready_o itself; no combinational loop.
- IDLE, accept with d < STREAM_COUNT:
  - Load output d; sel <= d.
  - Next state: ROUTE if !s_last_i, else stay IDLE.
- IDLE, accept with d >= STREAM_COUNT:
  - Beat is discarded.
  - Next state: DROP if !s_last_i, else stay IDLE.
- ROUTE: each accepted beat loads output sel; s_dest_i is ignored. An accepted beat with s_last_i=1 returns to IDLE.
- DROP: all beats are accepted and discarded. An accepted beat with s_last_i=1 returns to IDLE.
- Output slice k, each clock edge:
  - Load (accepted beat targeted at k): register data, qos and last; m_valid_o[k] <= 1.
  - Else if m_ready_i[k]: m_valid_o[k] <= 0. Data fields hold their last value.
  - Load and drain in the same cycle: the load wins, so valid stays 1. This gives full throughput of 1 beat per cycle.
- Latency: an input beat appears on m_*_o[d] 1 cycle after acceptance.
- Non-target outputs are never disturbed by traffic for another output.
- A back-to-back new packet in IDLE may target a different output in the next cycle, with no bubble.
- Protocol rules:
  - A valid output beat holds its value while m_ready_i[k]=0.
  - m_valid_o never depends combinationally on m_ready_i.
- Reset mid-packet: the packet is abandoned and outputs are flushed. The remainder of the packet arriving after reset is treated as a new packet: its first beat's s_dest_i is used.
- No reordering: beats within a packet leave in input order on one output.

Optional Feature:
- STREAM_DEMUX_DROP_CNT_EN defined:
  - Adds drop_cnt_o, output, 16 bits.
  - Increments by 1 on each accepted s_last_i beat of a dropped packet. This includes a single-beat drop in IDLE.
  - Saturates at 16'hFFFF; resets to 0.
- Not defined: the port is absent and drop behaviour is otherwise identical.

Test Plan:
- STREAM_COUNT=2, all m_ready_i=1:
  - Stimulus: 3-beat packet dest=1, data 0x11, 0x22, 0x33, qos=5.
  - Expect: output 1 shows the beats on consecutive cycles, each 1 cycle after acceptance, last=1 on 0x33.
  - Expect: output 0 valid stays 0; busy_o=1 between beats 1 and 3.
- Back-to-back packets:
  - Stimulus: single-beat dest=0 (0xA0), then immediately single-beat dest=1 (0xB1).
  - Expect: s_ready_o stays 1; m_valid_o = 01 then 10 on adjacent cycles.
- Backpressure:
  - Stimulus: m_ready_i[0]=0 during a 2-beat packet to output 0.
  - Expect: first beat held stable, s_ready_o=0 for the second beat.
  - Release ready: second beat accepted in the same cycle as the drain, m_valid_o[0] stays 1.
- Drop:
  - Stimulus: 2-beat packet dest=3 (out of range), followed by 1-beat dest=0.
  - Expect: both dropped beats accepted with no output activity; the next packet routes to output 0.
  - With STREAM_DEMUX_DROP_CNT_EN: drop_cnt_o goes 0 -> 1.
- Locked dest:
  - Stimulus: s_dest_i changes from 0 to 1 on beat 2 of a 3-beat packet.
  - Expect: all 3 beats exit on output 0.
- Reset mid-packet:
  - Stimulus: assert rst after beat 1 of a 3-beat packet with output 1 valid and m_ready_i[1]=0.
  - Expect: m_valid_o=00 immediately (asynchronous), busy_o=0.
  - After release, the next beat with dest=0 routes to output 0.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: steers each packet of one QoS stream to one of STREAM_COUNT outputs, each with a one-beat slice.
// Define STREAM_DEMUX_DROP_CNT_EN to add drop_cnt_o, a saturating count of discarded packets.
module stream_demux #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 2,
    parameter int T_DEST_WIDTH = $clog2(STREAM_COUNT) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH-1:0]              s_data_i,
    input  logic [T_QOS__WIDTH-1:0]              s_qos_i,
    input  logic [T_DEST_WIDTH-1:0]              s_dest_i,
    input  logic                                 s_last_i,
    input  logic                                 s_valid_i,
    output logic                                 s_ready_o,
    output logic [STREAM_COUNT*T_DATA_WIDTH-1:0] m_data_o,
    output logic [STREAM_COUNT*T_QOS__WIDTH-1:0] m_qos_o,
    output logic [STREAM_COUNT-1:0]              m_last_o,
    output logic [STREAM_COUNT-1:0]              m_valid_o,
    input  logic [STREAM_COUNT-1:0]              m_ready_i,
    output logic                                 busy_o
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]                          drop_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [T_DEST_WIDTH-1:0]   sel;
    logic [T_DEST_WIDTH-1:0]   dest_eff;
    logic                      dest_in_range;
    logic                      slot_free;
    logic                      route_beat;
    logic                      accept;
    logic [STREAM_COUNT-1:0]   load;

    assign dest_in_range = (s_dest_i < T_DEST_WIDTH'(STREAM_COUNT));
    assign busy_o        = (state != IDLE);

    // State register: sel is only captured on the first beat, which locks routing for the packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            if (accept && (state == IDLE) && dest_in_range) begin
                sel <= s_dest_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!s_last_i) begin
                        state_nxt = dest_in_range ? ROUTE : DROP;
                    end
                end
                ROUTE, DROP: begin
                    if (s_last_i) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Ready looks only at the target slice's valid and its downstream ready, never at itself.
    always_comb begin
        dest_eff   = (state == IDLE) ? s_dest_i : sel;
        slot_free  = 1'b0;
        route_beat = 1'b0;
        s_ready_o  = 1'b0;
        for (int k = 0; k < STREAM_COUNT; k++) begin
            if (dest_eff == T_DEST_WIDTH'(k)) begin
                slot_free = ~m_valid_o[k] | m_ready_i[k];
            end
        end
        case (state)
            IDLE: begin
                route_beat = dest_in_range;
                s_ready_o  = dest_in_range ? slot_free : 1'b1;
            end
            ROUTE: begin
                route_beat = 1'b1;
                s_ready_o  = slot_free;
            end
            DROP: begin
                s_ready_o = 1'b1;
            end
            default: s_ready_o = 1'b0;
        endcase
        if (rst) begin
            s_ready_o = 1'b0;
        end
        accept = s_valid_i & s_ready_o;
        for (int k = 0; k < STREAM_COUNT; k++) begin
            load[k] = accept & route_beat & (dest_eff == T_DEST_WIDTH'(k));
        end
    end

    // Output slices: a load in the same cycle as a drain keeps valid high for full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_o <= '0;
            m_data_o  <= '0;
            m_qos_o   <= '0;
            m_last_o  <= '0;
        end else begin
            for (int k = 0; k < STREAM_COUNT; k++) begin
                if (load[k]) begin
                    m_valid_o[k]                                <= 1'b1;
                    m_data_o[k*T_DATA_WIDTH +: T_DATA_WIDTH]    <= s_data_i;
                    m_qos_o[k*T_QOS__WIDTH +: T_QOS__WIDTH]     <= s_qos_i;
                    m_last_o[k]                                 <= s_last_i;
                end else if (m_ready_i[k]) begin
                    m_valid_o[k] <= 1'b0;
                end
            end
        end
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic drop_last;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    assign drop_last = accept & ~route_beat & s_last_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_o <= '0;
        end else if (drop_last) begin
            drop_cnt_o <= sat_inc16(drop_cnt_o);
        end
    end
`endif

endmodule
